// File: rtl/carry_chain_adder_if.sv
// Handshake and operand/result bundle for carry_chain_adder.
// OV exists only when CARRY_CHAIN_ADDER_OVF_EN is defined.
interface carry_chain_adder_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
);
    localparam int unsigned NSEG = WIDTH / SEG;

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] DI;
    logic             CI;
    logic             CYINIT;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] O;
    logic [NSEG-1:0]  CO;
`ifdef CARRY_CHAIN_ADDER_OVF_EN
    logic             OV;
`endif

    modport master (
        output IN_VALID, A, DI, CI, CYINIT, SUB, OUT_READY,
`ifdef CARRY_CHAIN_ADDER_OVF_EN
        input  OV,
`endif
        input  IN_READY, OUT_VALID, O, CO
    );

    modport slave (
        input  IN_VALID, A, DI, CI, CYINIT, SUB, OUT_READY,
`ifdef CARRY_CHAIN_ADDER_OVF_EN
        output OV,
`endif
        output IN_READY, OUT_VALID, O, CO
    );
endinterface

// File: rtl/carry_chain_adder.sv
// Pipelined segmented adder/subtractor: one SEG-bit carry segment per stage.
// Define CARRY_CHAIN_ADDER_OVF_EN to add the registered signed-overflow output OV.
module carry_chain_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input logic                CLK,
    input logic                RST_N,
    carry_chain_adder_if.slave bus
);
    localparam int unsigned NSEG = WIDTH / SEG;

    logic             advance;
    logic             cin;
    logic [SEG:0]     seg_sum;

    logic [WIDTH-1:0] a_d   [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_d   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] s_d   [NSEG];
    logic [WIDTH-1:0] s_q   [NSEG];
    logic             cy_d  [NSEG];
    logic             cy_q  [NSEG];
    logic [NSEG-1:0]  co_d  [NSEG];
    logic [NSEG-1:0]  co_q  [NSEG];
    logic             vld_d [NSEG];
    logic             vld_q [NSEG];
`ifdef CARRY_CHAIN_ADDER_OVF_EN
    logic             ov_d;
    logic             ov_q;
`endif

    // Whole pipeline moves as one; a full output register freezes every stage.
    assign advance = !vld_q[NSEG-1] || bus.OUT_READY;

    always_comb begin
        cin      = bus.SUB | bus.CI | bus.CYINIT;
        a_d[0]   = bus.A;
        b_d[0]   = bus.SUB ? ~bus.DI : bus.DI;
        s_d[0]   = '0;
        co_d[0]  = '0;
        vld_d[0] = bus.IN_VALID;
        seg_sum  = {1'b0, bus.A[SEG-1:0]} + {1'b0, b_d[0][SEG-1:0]} + {{SEG{1'b0}}, cin};
        s_d[0][SEG-1:0] = seg_sum[SEG-1:0];
        cy_d[0]    = seg_sum[SEG];
        co_d[0][0] = seg_sum[SEG];
        // Stage k adds segment k using the carry registered by stage k-1;
        // higher operand bits and lower result bits ride along unchanged.
        for (int unsigned k = 1; k < NSEG; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = s_q[k-1];
            co_d[k]  = co_q[k-1];
            vld_d[k] = vld_q[k-1];
            seg_sum  = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, cy_q[k-1]};
            s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            cy_d[k]    = seg_sum[SEG];
            co_d[k][k] = seg_sum[SEG];
        end
    end

`ifdef CARRY_CHAIN_ADDER_OVF_EN
    // Same-sign operands giving a different-sign result is equivalent to
    // carry-into-MSB XOR carry-out-of-MSB.
    always_comb begin
        ov_d = (a_d[NSEG-1][WIDTH-1] == b_d[NSEG-1][WIDTH-1])
            && (s_d[NSEG-1][WIDTH-1] != a_d[NSEG-1][WIDTH-1]);
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
                co_q[k]  <= '0;
                vld_q[k] <= 1'b0;
            end
`ifdef CARRY_CHAIN_ADDER_OVF_EN
            ov_q <= 1'b0;
`endif
        end else if (advance) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                cy_q[k]  <= cy_d[k];
                co_q[k]  <= co_d[k];
                vld_q[k] <= vld_d[k];
            end
`ifdef CARRY_CHAIN_ADDER_OVF_EN
            ov_q <= ov_d;
`endif
        end
    end

    assign bus.IN_READY  = advance;
    assign bus.OUT_VALID = vld_q[NSEG-1];
    assign bus.O         = s_q[NSEG-1];
    assign bus.CO        = co_q[NSEG-1];
`ifdef CARRY_CHAIN_ADDER_OVF_EN
    assign bus.OV        = ov_q;
`endif

endmodule

// File: tb/tb_carry_chain_adder.sv
// Scoreboard bench for carry_chain_adder (WIDTH=16, SEG=4) with directed vectors.
// Define CARRY_CHAIN_ADDER_OVF_EN to also check OV.
module tb_carry_chain_adder;
    localparam int NSEG = 4;

    typedef struct {
        logic [15:0] o;
        logic [3:0]  co;
        logic        ov;
        int          key;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   stalls;
    bit   seen;
    exp_t sb[$];

    carry_chain_adder_if #(.WIDTH(16), .SEG(4)) bus ();

    carry_chain_adder #(.WIDTH(16), .SEG(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency key: cycle count minus stalled edges is fixed per transaction.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.OUT_VALID && !bus.OUT_READY) stalls <= stalls + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] di, input logic ci,
                        input logic cy, input logic sub, input logic [15:0] eo,
                        input logic [3:0] eco, input logic eov);
        exp_t e;
        int   waited;
        bus.A = a; bus.DI = di; bus.CI = ci; bus.CYINIT = cy; bus.SUB = sub;
        bus.IN_VALID = 1'b1;
        waited = 0;
        #1;
        while (!bus.IN_READY && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check("in_ready_wait", 32'(bus.IN_READY), 32'd1);
        if (bus.IN_READY) begin
            e.o = eo; e.co = eco; e.ov = eov;
            e.key = cyc + NSEG - stalls;
            sb.push_back(e);
            @(posedge clk);
        end
        #1 bus.IN_VALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk); #3;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares the queue head every cycle the output is presented.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (bus.OUT_VALID) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.OUT_VALID), 32'd0);
                end else begin
                    check("O", 32'(bus.O), 32'(sb[0].o));
                    check("CO", 32'(bus.CO), 32'(sb[0].co));
`ifdef CARRY_CHAIN_ADDER_OVF_EN
                    check("OV", 32'(bus.OV), 32'(sb[0].ov));
`endif
                    if (!seen) check("latency", 32'(cyc - stalls), 32'(sb[0].key));
                    seen = 1'b1;
                    if (bus.OUT_READY) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; stalls = 0; seen = 1'b0;
        bus.IN_VALID = 1'b0; bus.A = '0; bus.DI = '0; bus.CI = 1'b0;
        bus.CYINIT = 1'b0; bus.SUB = 1'b0; bus.OUT_READY = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_O", 32'(bus.O), 32'd0);
        check("rst_CO", 32'(bus.CO), 32'd0);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.OUT_READY = 1'b1;
        @(negedge clk);

        // Wrap, subtract, carry-in sources, overflow corners
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1111, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b1, 16'hFFFE, 4'b0000, 1'b0);
        send(16'h0007, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0002, 4'b1111, 1'b0);
        send(16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1235, 4'b0000, 1'b0);
        send(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1235, 4'b0000, 1'b0);
        send(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1235, 4'b0000, 1'b0);
        send(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 4'b0000, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0111, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 4'b1000, 1'b1);
        wait_drain();

        // Bubbles between transactions
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 4'b0011, 1'b0);
        repeat (2) @(negedge clk);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 16'h1000, 4'b0111, 1'b0);
        repeat (1) @(negedge clk);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 4'b0000, 1'b0);
        wait_drain();

        // Back-to-back with a three-cycle output stall
        fork
            begin
                send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 4'b0000, 1'b0);
                send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 4'b0011, 1'b0);
                send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 16'h1000, 4'b0111, 1'b0);
                send(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0FFF, 4'b1000, 1'b0);
                send(16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0, 16'hBE01, 4'b0011, 1'b0);
                send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b1111, 1'b0);
                send(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0000, 1'b1);
                send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                bus.OUT_READY = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("in_ready_stall", 32'(bus.IN_READY), 32'd0);
                    check("out_valid_stall", 32'(bus.OUT_VALID), 32'd1);
                    @(negedge clk);
                end
                bus.OUT_READY = 1'b1;
            end
        join
        wait_drain();

        // Asynchronous reset with transactions in flight
        send(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2222, 4'b0000, 1'b0);
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0005, 4'b0000, 1'b0);
        send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0030, 4'b0000, 1'b0);
        bus.OUT_READY = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("async_rst_O", 32'(bus.O), 32'd0);
        check("async_rst_CO", 32'(bus.CO), 32'd0);
        check("async_rst_in_ready", 32'(bus.IN_READY), 32'd1);
`ifdef CARRY_CHAIN_ADDER_OVF_EN
        check("async_rst_OV", 32'(bus.OV), 32'd0);
`endif
        sb.delete();
        seen = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("no_stale_out", 32'(bus.OUT_VALID), 32'd0);
        end
        send(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, 16'h0406, 4'b0000, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
